// File: rtl/mult_seq_param.sv
// Parametrised sequential multiplier: WIDTH x WIDTH product built from A_CHUNK x B_CHUNK
// partial products, one per cycle, with signed/unsigned mode and fixed latency.
module mult_seq_param #(
    parameter int WIDTH   = 32,
    parameter int A_CHUNK = 8,
    parameter int B_CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int NA = WIDTH / A_CHUNK;
    localparam int NB = WIDTH / B_CHUNK;
    localparam int IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int JW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(PW);
    localparam int CW = A_CHUNK + B_CHUNK;

    localparam logic [IW-1:0]    I_LAST = IW'(NA - 1);
    localparam logic [JW-1:0]    J_LAST = JW'(NB - 1);
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P  = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [WIDTH-1:0]  a_mag_r, b_mag_r;
    logic              neg_r;
    logic [PW-1:0]     acc_r;
    logic [IW-1:0]     i_r;
    logic [JW-1:0]     j_r;
    logic              busy_r, done_r;
    logic [PW-1:0]     product_r;

    logic              last_s;
    logic [WIDTH-1:0]  a_abs_s, b_abs_s;
    logic              neg_s;
    logic [A_CHUNK-1:0] a_chunk_s;
    logic [B_CHUNK-1:0] b_chunk_s;
    logic [CW-1:0]     pp_s;
    logic [SW-1:0]     shamt_s;
    logic [PW-1:0]     addend_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

    assign last_s = (i_r == I_LAST) && (j_r == J_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand magnitudes, result sign and the current shifted partial product
    always_comb begin
        neg_s = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        if (is_signed && a[WIDTH-1]) begin
            a_abs_s = ~a + ONE_W;
        end else begin
            a_abs_s = a;
        end
        if (is_signed && b[WIDTH-1]) begin
            b_abs_s = ~b + ONE_W;
        end else begin
            b_abs_s = b;
        end
        a_chunk_s = A_CHUNK'(a_mag_r >> (int'(i_r) * A_CHUNK));
        b_chunk_s = B_CHUNK'(b_mag_r >> (int'(j_r) * B_CHUNK));
        pp_s      = {{B_CHUNK{1'b0}}, a_chunk_s} * {{A_CHUNK{1'b0}}, b_chunk_s};
        shamt_s   = SW'(int'(i_r) * A_CHUNK + int'(j_r) * B_CHUNK);
        addend_s  = PW'(pp_s) << shamt_s;
    end

    // Operand capture, accumulation, result commit and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            a_mag_r   <= {WIDTH{1'b0}};
            b_mag_r   <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            acc_r     <= {PW{1'b0}};
            i_r       <= {IW{1'b0}};
            j_r       <= {JW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {PW{1'b0}};
        end else begin
            done_r <= (state_r == FIX);
            busy_r <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_mag_r <= a_abs_s;
                        b_mag_r <= b_abs_s;
                        neg_r   <= neg_s;
                        acc_r   <= {PW{1'b0}};
                        i_r     <= {IW{1'b0}};
                        j_r     <= {JW{1'b0}};
                    end
                end
                RUN: begin
                    acc_r <= acc_r + addend_s;
                    // i walks the a-chunks fastest; j advances on each wrap
                    if (i_r == I_LAST) begin
                        i_r <= {IW{1'b0}};
                        j_r <= j_r + 1'b1;
                    end else begin
                        i_r <= i_r + 1'b1;
                    end
                end
                FIX: begin
                    if (neg_r) begin
                        product_r <= ~acc_r + ONE_P;
                    end else begin
                        product_r <= acc_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param at three geometries (16/4/8, 32/8/16, 64/16/32),
// all with eight partial products, driven in lockstep from one stimulus sequence.
module tb_mult_seq_param;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [15:0]  a16, b16;
    logic [31:0]  a32, b32;
    logic [63:0]  a64, b64;
    logic         busy16, busy32, busy64;
    logic         done16, done32, done64;
    logic [31:0]  p16;
    logic [63:0]  p32;
    logic [127:0] p64;

    int tests = 0;
    int fails = 0;
    logic [63:0] prev_p32 = 64'd0;

    mult_seq_param #(.WIDTH(16), .A_CHUNK(4), .B_CHUNK(8)) u_w16 (
        .clk(clk), .reset(reset), .start(start), .a(a16), .b(b16),
        .is_signed(is_signed), .busy(busy16), .done(done16), .product(p16));

    mult_seq_param #(.WIDTH(32), .A_CHUNK(8), .B_CHUNK(16)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a32), .b(b32),
        .is_signed(is_signed), .busy(busy32), .done(done32), .product(p32));

    mult_seq_param #(.WIDTH(64), .A_CHUNK(16), .B_CHUNK(32)) u_w64 (
        .clk(clk), .reset(reset), .start(start), .a(a64), .b(b64),
        .is_signed(is_signed), .busy(busy64), .done(done64), .product(p64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend both operands to full product width and multiply modulo 2^(2W)
    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [31:0] xe, ye;
        xe = s ? {{16{x[15]}}, x} : {16'd0, x};
        ye = s ? {{16{y[15]}}, y} : {16'd0, y};
        return xe * ye;
    endfunction

    function automatic logic [127:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [127:0] xe, ye;
        xe = s ? {{64{x[63]}}, x} : {64'd0, x};
        ye = s ? {{64{y[63]}}, y} : {64'd0, y};
        return xe * ye;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x16, input logic [15:0] y16,
                         input logic [31:0] x32, input logic [31:0] y32,
                         input logic [63:0] x64, input logic [63:0] y64, input logic s);
        a16 = x16; b16 = y16; a32 = x32; b32 = y32; a64 = x64; b64 = y64; is_signed = s;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy32 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag,
                                input logic [15:0] x16, input logic [15:0] y16,
                                input logic [63:0] x64, input logic [63:0] y64, input logic s,
                                input logic [63:0] exp32, input int exp_n, input int n);
        chk({tag, " busy_cycles"}, 128'(n), 128'(exp_n));
        chk({tag, " done32"}, 128'(done32), 128'd1);
        chk({tag, " done16"}, 128'(done16), 128'd1);
        chk({tag, " done64"}, 128'(done64), 128'd1);
        chk({tag, " busy_all"}, 128'({busy16, busy32, busy64}), 128'd0);
        chk({tag, " p32"}, 128'(p32), 128'(exp32));
        chk({tag, " p16"}, 128'(p16), 128'(ref16(x16, y16, s)));
        chk({tag, " p64"}, p64, ref64(x64, y64, s));
        prev_p32 = exp32;
    endtask

    task automatic run_op(input string tag,
                          input logic [15:0] x16, input logic [15:0] y16,
                          input logic [31:0] x32, input logic [31:0] y32,
                          input logic [63:0] x64, input logic [63:0] y64, input logic s,
                          input logic [63:0] exp32);
        int n;
        @(negedge clk);
        drive(x16, y16, x32, y32, x64, y64, s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_c1"}, 128'(busy32), 128'd1);
        chk({tag, " hold_c1"}, 128'(p32), 128'(prev_p32));
        wait_done(n);
        check_result(tag, x16, y16, x64, y64, s, exp32, 9, n);
        @(negedge clk);
        chk({tag, " done_drop"}, 128'(done32), 128'd0);
    endtask

    initial begin
        int n;
        int dseen;
        reset = 1'b1;
        start = 1'b0;
        drive(16'd0, 16'd0, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst busy", 128'({busy16, busy32, busy64}), 128'd0);
        chk("rst done", 128'({done16, done32, done64}), 128'd0);
        chk("rst p32", 128'(p32), 128'd0);
        chk("rst p16p64", p64 | 128'(p16), 128'd0);
        reset = 1'b0;

        // Unsigned
        run_op("u2x3", 16'd2, 16'd3, 32'd2, 32'd3, 64'd2, 64'd3, 1'b0, 64'd6);
        run_op("u123x456", 16'd123, 16'd456, 32'd123, 32'd456, 64'd123, 64'd456, 1'b0, 64'd56088);
        run_op("u1e8sq", 16'd10000, 16'd10000, 32'd100000000, 32'd100000000,
               64'd100000000, 64'd100000000, 1'b0, 64'h002386F26FC10000);
        run_op("umaxsq", 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);

        // Signed
        run_op("sm1xm1", 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd1);
        run_op("sminx3", 16'h8000, 16'd3, 32'h80000000, 32'd3,
               64'h8000000000000000, 64'd3, 1'b1, 64'hFFFFFFFE80000000);
        run_op("sm5x0", 16'hFFFB, 16'd0, 32'hFFFFFFFB, 32'd0,
               64'hFFFFFFFFFFFFFFFB, 64'd0, 1'b1, 64'd0);

        // Start while busy is ignored
        @(negedge clk);
        drive(16'd7, 16'd9, 32'd7, 32'd9, 64'd7, 64'd9, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(16'd5, 16'hFFFF, 32'd5, 32'hFFFFFFFF, 64'd5, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check_result("ignore", 16'd7, 16'd9, 64'd7, 64'd9, 1'b0, 64'd63, 6, n);
        dseen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done32 === 1'b1 || busy32 === 1'b1) dseen++;
        end
        chk("ignore no_second_op", 128'(dseen), 128'd0);

        // Start held through the done cycle: back-to-back operations
        @(negedge clk);
        drive(16'd11, 16'd13, 32'd11, 32'd13, 64'd11, 64'd13, 1'b0);
        start = 1'b1;
        @(negedge clk);
        wait_done(n);
        check_result("b2b first", 16'd11, 16'd13, 64'd11, 64'd13, 1'b0, 64'd143, 9, n);
        drive(16'hFFFE, 16'd3, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFFFFFFFFFE, 64'd3, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted busy", 128'(busy32), 128'd1);
        chk("b2b accepted done", 128'(done32), 128'd0);
        chk("b2b hold", 128'(p32), 128'd143);
        wait_done(n);
        check_result("b2b second", 16'hFFFE, 16'd3, 64'hFFFFFFFFFFFFFFFE, 64'd3, 1'b1,
                     64'hFFFFFFFFFFFFFFFA, 9, n);
        @(negedge clk);
        chk("b2b done_drop", 128'(done32), 128'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        drive(16'd300, 16'd200, 32'd300, 32'd200, 64'd300, 64'd200, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", 128'({busy16, busy32, busy64}), 128'd0);
        chk("midrst done", 128'({done16, done32, done64}), 128'd0);
        chk("midrst p32", 128'(p32), 128'd0);
        chk("midrst p16p64", p64 | 128'(p16), 128'd0);
        prev_p32 = 64'd0;
        run_op("after_rst", 16'd300, 16'd200, 32'd300, 32'd200, 64'd300, 64'd200, 1'b0, 64'd60000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
